// File: rtl/jvm_pkg.sv
// Shared definitions for the JVM front end: fetch FSM states, opcode constants
// and the big-endian byte-lane select used by the bytecode fetch path.
package jvm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDeliver
  } fetch_state_t;

  // Prefix opcode that widens the operand of the following instruction.
  localparam logic [7:0] OPC_WIDE = 8'hC4;

  // Offset 0 is the most significant byte of the word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] offset);
    logic [7:0] lane;
    unique case (offset)
      2'd0:    lane = word[31:24];
      2'd1:    lane = word[23:16];
      2'd2:    lane = word[15:8];
      default: lane = word[7:0];
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One-word line buffer in front of the code RAM: holds the last fetched word
// and its word address, reports a hit for the current PC and selects its byte.
module fetch_line_buffer
  import jvm_pkg::*;
#(
  parameter int unsigned WordAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic [WordAddrWidth-1:0] load_addr_i,
  input  logic [31:0]              load_data_i,
  input  logic [WordAddrWidth-1:0] lookup_addr_i,
  input  logic [1:0]               offset_i,
  output logic                     hit_o,
  output logic [7:0]               byte_o
);

  logic [31:0]              buf_data_q, buf_data_d;
  logic [WordAddrWidth-1:0] buf_addr_q, buf_addr_d;
  logic                     buf_valid_q, buf_valid_d;

  // Clear wins over a load so an aborted fetch never leaves a valid line behind.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_addr_d  = buf_addr_q;
    buf_valid_d = buf_valid_q;
    if (clear_i) begin
      buf_valid_d = 1'b0;
    end else if (load_i) begin
      buf_data_d  = load_data_i;
      buf_addr_d  = load_addr_i;
      buf_valid_d = 1'b1;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_data_q  <= '0;
      buf_addr_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_addr_q  <= buf_addr_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign hit_o  = buf_valid_q && (buf_addr_q == lookup_addr_i);
  assign byte_o = byte_lane(buf_data_q, offset_i);

endmodule

// File: rtl/bytecode_fetch.sv
// Byte-serial bytecode fetch unit: delivers one code byte per start request,
// reading 32-bit words from a synchronous RAM through a one-word line buffer.
module bytecode_fetch
  import jvm_pkg::*;
#(
  parameter int unsigned SIZE          = 1024,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pc_reset,
  output logic                     ready,
  output logic [7:0]               next_byte,
  output logic                     end_of_code,
  output logic [ADDRESS_WIDTH:0]   pc,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned PcWidth   = ADDRESS_WIDTH + 1;
  localparam int unsigned WordWidth = ADDRESS_WIDTH - 2;
  localparam logic [PcWidth-1:0] SizePc = PcWidth'(SIZE);

  fetch_state_t           state_q, state_d;
  logic [PcWidth-1:0]     pc_q, pc_d;
  logic                   ready_q, ready_d;
  logic [7:0]             next_byte_q, next_byte_d;
  logic                   eoc_q, eoc_d;
  logic                   rd_en_q, rd_en_d;
  logic [WordWidth-1:0]   mem_addr_q, mem_addr_d;

  logic [WordWidth-1:0]   word_addr;
  logic [1:0]             byte_offset;
  logic                   buf_hit;
  logic [7:0]             buf_byte;
  logic                   buf_load;

  assign word_addr   = pc_q[ADDRESS_WIDTH-1:2];
  assign byte_offset = pc_q[1:0];
  // The PC cannot move between REQ and WAIT, so the issued address tags the line.
  assign buf_load    = (state_q == StWait) && !pc_reset;

  fetch_line_buffer #(
    .WordAddrWidth(WordWidth)
  ) u_line_buffer (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (pc_reset),
    .load_i       (buf_load),
    .load_addr_i  (mem_addr_q),
    .load_data_i  (mem_rdata),
    .lookup_addr_i(word_addr),
    .offset_i     (byte_offset),
    .hit_o        (buf_hit),
    .byte_o       (buf_byte)
  );

  // Next-state and registered-output logic; ready and mem_rd_en are computed
  // one cycle early so they appear in the DELIVER and REQ cycles respectively.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ready_d     = 1'b0;
    next_byte_d = next_byte_q;
    eoc_d       = eoc_q;
    rd_en_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    if (pc_reset) begin
      state_d = StIdle;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (pc_q >= SizePc) begin
              state_d     = StDeliver;
              ready_d     = 1'b1;
              eoc_d       = 1'b1;
              next_byte_d = 8'h00;
            end else if (buf_hit) begin
              state_d     = StDeliver;
              ready_d     = 1'b1;
              eoc_d       = 1'b0;
              next_byte_d = buf_byte;
            end else begin
              state_d    = StReq;
              rd_en_d    = 1'b1;
              mem_addr_d = word_addr;
            end
          end
        end
        StReq: begin
          state_d = StWait;
        end
        StWait: begin
          state_d     = StDeliver;
          ready_d     = 1'b1;
          eoc_d       = 1'b0;
          next_byte_d = byte_lane(mem_rdata, byte_offset);
        end
        StDeliver: begin
          state_d = StIdle;
          // Saturate at SIZE; the end-of-code delivery leaves the PC alone.
          if (!eoc_q && (pc_q < SizePc)) begin
            pc_d = pc_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ready_q     <= 1'b0;
      next_byte_q <= 8'h00;
      eoc_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ready_q     <= ready_d;
      next_byte_q <= next_byte_d;
      eoc_q       <= eoc_d;
      rd_en_q     <= rd_en_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign ready       = ready_q;
  assign next_byte   = next_byte_q;
  assign end_of_code = eoc_q;
  assign pc          = pc_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch with a small synchronous code RAM.
module tb_bytecode_fetch;

  localparam int unsigned SIZE = 8;
  localparam int unsigned AW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pc_reset = 1'b0;
  logic          ready;
  logic [7:0]    next_byte;
  logic          end_of_code;
  logic [AW:0]   pc;
  logic          mem_rd_en;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_rdata = '0;

  logic [31:0] ram [4];
  int          rd_count = 0;
  int          last_rd_addr = -1;
  bit          prev_rd = 1'b0;
  bit          rd_consec = 1'b0;

  int checks = 0;
  int failures = 0;

  bytecode_fetch #(
    .SIZE(SIZE),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_reset   (pc_reset),
    .ready      (ready),
    .next_byte  (next_byte),
    .end_of_code(end_of_code),
    .pc         (pc),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM plus read bookkeeping.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata    <= ram[mem_addr];
      rd_count     <= rd_count + 1;
      last_rd_addr <= int'(mem_addr);
    end
    if (mem_rd_en && prev_rd) rd_consec <= 1'b1;
    prev_rd <= mem_rd_en;
  end

  function automatic logic [7:0] code_byte(input int addr);
    logic [31:0] w;
    w = ram[addr / 4];
    return 8'(w >> (8 * (3 - (addr % 4))));
  endfunction

  // Issue one start at a negedge; return at the negedge after ready (PC updated).
  task automatic do_start(output bit got, output int lat, output int reads,
                          output logic [7:0] b, output logic eoc);
    int r0;
    r0 = rd_count;
    got = 1'b0; lat = 0; b = 8'h00; eoc = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (ready) begin
        got = 1'b1; lat = k; b = next_byte; eoc = end_of_code;
        break;
      end
      @(negedge clk);
    end
    if (got) @(negedge clk);
    reads = rd_count - r0;
  endtask

  task automatic do_pc_reset();
    pc_reset = 1'b1;
    @(negedge clk);
    pc_reset = 1'b0;
  endtask

  task automatic test_reset();
    ram[0] = 32'h10_05_3C_B1;
    ram[1] = 32'hAA_00_00_00;
    ram[2] = '0;
    ram[3] = '0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (next_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", next_byte); end
    checks++; if (end_of_code !== 1'b0) begin failures++; $display("FAIL reset_eoc got=%b exp=0", end_of_code); end
    checks++; if (pc !== '0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", mem_rd_en); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_line_buffer();
    logic [7:0] exp_b [4];
    int         exp_lat [4];
    bit got; int lat; int reads; logic [7:0] b; logic eoc; int r0;
    exp_b = '{8'h10, 8'h05, 8'h3C, 8'hB1};
    exp_lat = '{3, 1, 1, 1};
    r0 = rd_count;
    for (int i = 0; i < 4; i++) begin
      do_start(got, lat, reads, b, eoc);
      checks++; if (!got) begin failures++; $display("FAIL lb_ready[%0d] got=none exp=pulse", i); end
      checks++; if (b !== exp_b[i]) begin failures++; $display("FAIL lb_byte[%0d] got=%h exp=%h", i, b, exp_b[i]); end
      checks++; if (lat != exp_lat[i]) begin failures++; $display("FAIL lb_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat[i]); end
    end
    checks++; if (rd_count - r0 != 1) begin failures++; $display("FAIL lb_reads got=%0d exp=1", rd_count - r0); end
    checks++; if (pc !== 5'd4) begin failures++; $display("FAIL lb_pc got=%0d exp=4", pc); end
    do_start(got, lat, reads, b, eoc);
    checks++; if (reads != 1 || last_rd_addr != 1) begin
      failures++; $display("FAIL lb_word1_read got=%0d@%0d exp=1@1", reads, last_rd_addr);
    end
    checks++; if (!got || b !== 8'hAA || lat != 3) begin
      failures++; $display("FAIL lb_word1_byte got=%h lat=%0d exp=aa lat=3", b, lat);
    end
  endtask

  task automatic test_end_of_code();
    bit got; int lat; int reads; logic [7:0] b; logic eoc;
    for (int i = 5; i < 8; i++) begin
      do_start(got, lat, reads, b, eoc);
      checks++; if (!got || b !== 8'h00 || eoc !== 1'b0 || lat != 1) begin
        failures++; $display("FAIL eoc_tail[%0d] got=%h eoc=%b lat=%0d exp=00 eoc=0 lat=1", i, b, eoc, lat);
      end
    end
    checks++; if (pc !== 5'd8) begin failures++; $display("FAIL eoc_pc_full got=%0d exp=8", pc); end
    for (int i = 0; i < 2; i++) begin
      do_start(got, lat, reads, b, eoc);
      checks++; if (!got || eoc !== 1'b1 || b !== 8'h00 || lat != 1) begin
        failures++; $display("FAIL eoc_deliver[%0d] got=%h eoc=%b lat=%0d exp=00 eoc=1 lat=1", i, b, eoc, lat);
      end
      checks++; if (reads != 0) begin failures++; $display("FAIL eoc_no_read[%0d] got=%0d exp=0", i, reads); end
      checks++; if (pc !== 5'd8) begin failures++; $display("FAIL eoc_pc_hold[%0d] got=%0d exp=8", i, pc); end
    end
  endtask

  task automatic test_pc_reset_in_wait();
    bit got; int lat; int reads; logic [7:0] b; logic eoc; int seen;
    do_pc_reset();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL prw_req got=%b exp=1", mem_rd_en); end
    @(negedge clk);
    pc_reset = 1'b1;
    @(negedge clk);
    pc_reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (ready) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL prw_no_ready got=%0d exp=0", seen); end
    checks++; if (pc !== '0) begin failures++; $display("FAIL prw_pc got=%0d exp=0", pc); end
    do_start(got, lat, reads, b, eoc);
    checks++; if (reads != 1 || !got || b !== 8'h10 || lat != 3) begin
      failures++; $display("FAIL prw_reread got=%h reads=%0d lat=%0d exp=10 reads=1 lat=3", b, reads, lat);
    end
  endtask

  task automatic test_start_with_pc_reset();
    bit got; int lat; int reads; logic [7:0] b; logic eoc; int seen; int r0;
    do_pc_reset();
    for (int i = 0; i < 5; i++) do_start(got, lat, reads, b, eoc);
    checks++; if (pc !== 5'd5) begin failures++; $display("FAIL spr_setup_pc got=%0d exp=5", pc); end
    r0 = rd_count;
    start = 1'b1;
    pc_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pc_reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (ready || mem_rd_en) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0 || rd_count != r0) begin
      failures++; $display("FAIL spr_dropped got=%0d activity exp=0", seen);
    end
    checks++; if (pc !== '0) begin failures++; $display("FAIL spr_pc got=%0d exp=0", pc); end
    do_start(got, lat, reads, b, eoc);
    checks++; if (!got || b !== 8'h10 || lat != 3 || reads != 1) begin
      failures++; $display("FAIL spr_idle_refetch got=%h lat=%0d exp=10 lat=3", b, lat);
    end
  endtask

  task automatic test_async_reset();
    bit got; int lat; int reads; logic [7:0] b; logic eoc;
    do_pc_reset();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL ar_in_req got=%b exp=1", mem_rd_en); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || next_byte !== 8'h00 || end_of_code !== 1'b0 ||
                  pc !== '0 || mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL ar_outputs got=r%b b%h e%b pc%0d rd%b a%0d exp=all zero",
               ready, next_byte, end_of_code, pc, mem_rd_en, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(got, lat, reads, b, eoc);
    checks++; if (!got || b !== 8'h10 || lat != 3 || reads != 1) begin
      failures++; $display("FAIL ar_resume got=%h lat=%0d reads=%0d exp=10 lat=3 reads=1", b, lat, reads);
    end
  endtask

  task automatic test_random();
    int m_pc; bit m_valid; int m_tag;
    bit got; int lat; int reads; logic [7:0] b; logic eoc;
    bit x_eoc; bit x_hit; logic [7:0] x_b; int x_lat; int x_reads;
    do_pc_reset();
    for (int i = 0; i < 4; i++) ram[i] = $urandom;
    m_pc = 0; m_valid = 1'b0; m_tag = 0;
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) begin
        do_pc_reset();
        m_pc = 0; m_valid = 1'b0;
        checks++; if (pc !== '0) begin failures++; $display("FAIL rnd_pc_reset[%0d] got=%0d exp=0", it, pc); end
      end else if (r == 1) begin
        @(negedge clk);
      end else begin
        x_eoc = (m_pc >= SIZE);
        x_hit = !x_eoc && m_valid && (m_tag == m_pc / 4);
        x_b = x_eoc ? 8'h00 : code_byte(m_pc);
        x_lat = (x_eoc || x_hit) ? 1 : 3;
        x_reads = (x_eoc || x_hit) ? 0 : 1;
        do_start(got, lat, reads, b, eoc);
        if (!x_eoc) begin
          if (!x_hit) begin m_valid = 1'b1; m_tag = m_pc / 4; end
          m_pc++;
        end
        checks++; if (!got || b !== x_b || eoc !== x_eoc) begin
          failures++; $display("FAIL rnd_byte[%0d] got=%h eoc=%b exp=%h eoc=%b", it, b, eoc, x_b, x_eoc);
        end
        checks++; if (lat != x_lat || reads != x_reads) begin
          failures++; $display("FAIL rnd_timing[%0d] got=lat%0d rd%0d exp=lat%0d rd%0d", it, lat, reads, x_lat, x_reads);
        end
        checks++; if (int'(pc) != m_pc) begin
          failures++; $display("FAIL rnd_pc[%0d] got=%0d exp=%0d", it, pc, m_pc);
        end
      end
    end
    checks++; if (rd_consec) begin failures++; $display("FAIL rd_en_single got=consecutive exp=single"); end
  endtask

  initial begin
    test_reset();
    test_line_buffer();
    test_end_of_code();
    test_pc_reset_in_wait();
    test_start_with_pc_reset();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
